// File: rtl/audio_pkg.sv
`default_nettype none
// ==== audio_pkg : widths, FSM encoding and sample helpers for the audio path ==== Rev 1.0
package audio_pkg;

  localparam int SAMPLE_W     = 16;
  localparam int CORE_AUDIO_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CAPT   = 3'd1,
    ST_FILT_L = 3'd2,
    ST_FILT_R = 3'd3,
    ST_OUT    = 3'd4
  } dcb_state_t;

  // Overflow of a 17-bit signed value shows as its two top bits disagreeing.
  function automatic logic [SAMPLE_W-1:0] sat16(input logic [SAMPLE_W:0] v);
    if (v[SAMPLE_W] != v[SAMPLE_W-1])
      return v[SAMPLE_W] ? 16'h8000 : 16'h7FFF;
    return v[SAMPLE_W-1:0];
  endfunction

  function automatic logic [SAMPLE_W-1:0] u9_to_s16(input logic [CORE_AUDIO_W-1:0] u);
    return {u, 7'd0} ^ 16'h8000;
  endfunction

endpackage
`default_nettype wire

// File: rtl/audio_tick_gen.sv
`default_nettype none
// ==== audio_tick_gen : divide-by-DIV counter giving a one-cycle tick ==== Rev 1.0
module audio_tick_gen #(
  parameter int DIV = 500
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/audio_dc_blocker.sv
`default_nettype none
// ==== audio_dc_blocker : 9-bit unsigned to 16-bit signed with time-shared DC-removal filter ====
// ==== Optional tape mix via AUDIO_EAR_MIX_EN ==== Rev 1.0
module audio_dc_blocker
  import audio_pkg::*;
#(
  parameter int CLKMHZ     = 24,
  parameter int SAMPLE_KHZ = 48,
  parameter int K          = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,
`ifdef AUDIO_EAR_MIX_EN
  input  logic                    ear,
`endif
  input  logic [CORE_AUDIO_W-1:0] audio_in_l,
  input  logic [CORE_AUDIO_W-1:0] audio_in_r,
  output logic [SAMPLE_W-1:0]     audio_out_l,
  output logic [SAMPLE_W-1:0]     audio_out_r,
  output logic                    sample_stb
);

  localparam int DIV   = CLKMHZ * 1000 / SAMPLE_KHZ;
  localparam int ACC_W = SAMPLE_W + K;

  dcb_state_t state, state_nxt;
  logic       tick;

  logic [CORE_AUDIO_W-1:0] in_l_q, in_r_q, in_sel;
`ifdef AUDIO_EAR_MIX_EN
  logic                    ear_q;
`endif
  logic signed [ACC_W-1:0] acc_l, acc_r, diff_ext;
  logic [SAMPLE_W-1:0]     hold_l, hold_r;
  logic [SAMPLE_W-1:0]     x_conv, x, dc, y;
  logic [SAMPLE_W:0]       diff;

  audio_tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Ticks arriving outside IDLE are dropped rather than queued.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (tick) state_nxt = ST_CAPT;
      ST_CAPT:   state_nxt = ST_FILT_L;
      ST_FILT_L: state_nxt = ST_FILT_R;
      ST_FILT_R: state_nxt = ST_OUT;
      ST_OUT:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sample_stb = (state == ST_OUT);
  end

  // One subtract/saturate path: left channel in CAPT, right channel in FILT_L.
  always_comb begin
    in_sel = (state == ST_FILT_L) ? in_r_q : in_l_q;
    dc     = (state == ST_FILT_L) ? acc_r[ACC_W-1:K] : acc_l[ACC_W-1:K];
  end

  assign x_conv = u9_to_s16(in_sel);
`ifdef AUDIO_EAR_MIX_EN
  assign x = sat16({x_conv[SAMPLE_W-1], x_conv} + (ear_q ? 17'h00800 : 17'h1F800));
`else
  assign x = x_conv;
`endif
  assign diff     = {x[SAMPLE_W-1], x} - {dc[SAMPLE_W-1], dc};
  assign diff_ext = ACC_W'($signed(diff));
  assign y        = sat16(diff);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_l_q      <= '0;
      in_r_q      <= '0;
`ifdef AUDIO_EAR_MIX_EN
      ear_q       <= 1'b0;
`endif
      acc_l       <= '0;
      acc_r       <= '0;
      hold_l      <= '0;
      hold_r      <= '0;
      audio_out_l <= '0;
      audio_out_r <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick) begin
            in_l_q <= audio_in_l;
            in_r_q <= audio_in_r;
`ifdef AUDIO_EAR_MIX_EN
            ear_q  <= ear;
`endif
          end
        end
        ST_CAPT: begin
          hold_l <= y;
          acc_l  <= acc_l + diff_ext;
        end
        ST_FILT_L: begin
          hold_r <= y;
          acc_r  <= acc_r + diff_ext;
        end
        ST_FILT_R: begin
          audio_out_l <= hold_l;
          audio_out_r <= hold_r;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_audio_dc_blocker.sv
`default_nettype none
// ==== tb_audio_dc_blocker : table, directed and random checks against a floor-division filter model ==== Rev 1.0
module tb_audio_dc_blocker;

  localparam int DIV_A = 500;
  localparam int K_A   = 10;
  localparam int DIV_B = 8;
  localparam int K_B   = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [8:0]  in_la, in_ra, in_lb, in_rb;
  logic [15:0] out_la, out_ra, out_lb, out_rb;
  logic        stb_a, stb_b;
`ifdef AUDIO_EAR_MIX_EN
  logic        ear_a, ear_b;
`endif

  // Full-rate instance for latency and strobe period at the real divider.
  audio_dc_blocker dut_a (
    .clk         (clk),
    .reset_n     (rst_a),
`ifdef AUDIO_EAR_MIX_EN
    .ear         (ear_a),
`endif
    .audio_in_l  (in_la),
    .audio_in_r  (in_ra),
    .audio_out_l (out_la),
    .audio_out_r (out_ra),
    .sample_stb  (stb_a)
  );

  // Fast instance (DIV 8, K 6) so long filter histories fit the cycle budget.
  audio_dc_blocker #(.CLKMHZ(1), .SAMPLE_KHZ(125), .K(K_B)) dut_b (
    .clk         (clk),
    .reset_n     (rst_b),
`ifdef AUDIO_EAR_MIX_EN
    .ear         (ear_b),
`endif
    .audio_in_l  (in_lb),
    .audio_in_r  (in_rb),
    .audio_out_l (out_lb),
    .audio_out_r (out_rb),
    .sample_stb  (stb_b)
  );

  typedef struct {
    logic [8:0] l;
    logic [8:0] r;
    int         el;
    int         er;
  } vec_t;

  int     n_vec = 0;
  int     n_bad = 0;
  longint acc_m [4];
  int     em_a  = 0;
  int     em_b  = 0;

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int s16(logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic longint clamp16(longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // One filter step: x = (u - 256) * 128, dc = floor(acc / 2^k), y = clamp(x - dc), acc += x - dc.
  function automatic int model_sample(int slot, int in9, int ear_mode, int k);
    longint x, dc, d, scale;
    scale = longint'(1) << k;
    x = longint'(in9 - 256) * 128;
    if (ear_mode != 0) x = clamp16(x + 2048 * ear_mode);
    if (acc_m[slot] >= 0) dc = acc_m[slot] / scale;
    else                  dc = -((-acc_m[slot] + scale - 1) / scale);
    d = x - dc;
    acc_m[slot] = acc_m[slot] + d;
    return int'(clamp16(d));
  endfunction

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic set_b(int l, int r);
    in_lb = 9'(l);
    in_rb = 9'(r);
  endtask

  task automatic reset_b();
    rst_b = 1'b0;
    tick_clk();
    tick_clk();
    rst_b = 1'b1;
    acc_m[2] = 0;
    acc_m[3] = 0;
  endtask

  task automatic check_a(string tag, int l9, int r9, int em);
    int el, er;
    el = model_sample(0, l9, em, K_A);
    er = model_sample(1, r9, em, K_A);
    check({tag, "_l"}, s16(out_la), el);
    check({tag, "_r"}, s16(out_ra), er);
  endtask

  task automatic check_b(string tag, int l9, int r9, int em);
    int el, er;
    el = model_sample(2, l9, em, K_B);
    er = model_sample(3, r9, em, K_B);
    check({tag, "_l"}, s16(out_lb), el);
    check({tag, "_r"}, s16(out_rb), er);
  endtask

  // Returns edges until the strobe; outputs must not move before it.
  task automatic wait_stb_a(output int n);
    logic [15:0] hl, hr;
    int          moved;
    hl = out_la; hr = out_ra; moved = 0; n = 0;
    do begin
      tick_clk();
      n++;
      if (!stb_a && (out_la !== hl || out_ra !== hr)) moved = 1;
    end while (!stb_a && n < 2 * DIV_A + 8);
    check("hold_a", moved, 0);
    if (!stb_a) check("stb_a_timeout", int'(stb_a), 1);
  endtask

  task automatic wait_stb_b(output int n);
    logic [15:0] hl, hr;
    int          moved;
    hl = out_lb; hr = out_rb; moved = 0; n = 0;
    do begin
      tick_clk();
      n++;
      if (!stb_b && (out_lb !== hl || out_rb !== hr)) moved = 1;
    end while (!stb_b && n < 4 * DIV_B + 8);
    check("hold_b", moved, 0);
    if (!stb_b) check("stb_b_timeout", int'(stb_b), 1);
  endtask

  initial begin
    vec_t tbl [6];
    int   n, el, er, yl, yr, prev_l, viol, first, cl, cr, pr;

    // Hand-derived from reset with K = 6 (floor division for dc).
    tbl[0] = '{9'h1FF, 9'h000,  32640, -32768};
    tbl[1] = '{9'h100, 9'h100,   -510,    512};
    tbl[2] = '{9'h100, 9'h1FF,   -502,  32767};
    tbl[3] = '{9'h000, 9'h000, -32768, -32768};
    tbl[4] = '{9'h180, 9'h080,  16410, -15885};
    tbl[5] = '{9'h100, 9'h100,   -230,    747};

`ifdef AUDIO_EAR_MIX_EN
    ear_a = 1'b0; ear_b = 1'b0; em_a = -1; em_b = -1;
`endif
    rst_a = 1'b0; rst_b = 1'b0;
    in_la = 9'h1FF; in_ra = 9'h1FF;
    set_b(9'h100, 9'h100);

    for (int i = 0; i < 10; i++) begin
      tick_clk();
      check("rst_out_l", s16(out_la), 0);
      check("rst_out_r", s16(out_ra), 0);
      check("rst_stb", int'(stb_a), 0);
    end

    // Edge count starts at the first edge that sees reset_n high.
    rst_a = 1'b1; acc_m[0] = 0; acc_m[1] = 0;
    wait_stb_a(n);
    check("first_stb_edges_a", n, DIV_A + 3);
`ifndef AUDIO_EAR_MIX_EN
    check("first_a_const_l", s16(out_la), 32640);
`endif
    check_a("first_a", 9'h1FF, 9'h1FF, em_a);

    rst_a = 1'b0; in_la = 9'h100; in_ra = 9'h100;
    tick_clk(); tick_clk();
    rst_a = 1'b1; acc_m[0] = 0; acc_m[1] = 0;
    for (int i = 0; i < 20; i++) begin
      wait_stb_a(n);
      check("period_a", n, (i == 0) ? DIV_A + 3 : DIV_A);
`ifndef AUDIO_EAR_MIX_EN
      check("midscale_zero_l", s16(out_la), 0);
`endif
      check_a("midscale", 9'h100, 9'h100, em_a);
    end

    set_b(tbl[0].l, tbl[0].r);
    reset_b();
    for (int i = 0; i < 6; i++) begin
      wait_stb_b(n);
      check("period_b", n, (i == 0) ? DIV_B + 3 : DIV_B);
      el = model_sample(2, int'(tbl[i].l), em_b, K_B);
      er = model_sample(3, int'(tbl[i].r), em_b, K_B);
`ifndef AUDIO_EAR_MIX_EN
      check("tbl_l", s16(out_lb), tbl[i].el);
      check("tbl_r", s16(out_rb), tbl[i].er);
`endif
      check("tbl_model_l", s16(out_lb), el);
      check("tbl_model_r", s16(out_rb), er);
      if (i < 5) set_b(tbl[i + 1].l, tbl[i + 1].r);
    end

    // Change inputs one cycle after the tick: the sample in flight keeps the old values.
    cl = 9'h1C0; cr = 9'h040;
    set_b(cl, cr);
    repeat (DIV_B - 3) tick_clk();
    set_b(9'h020, 9'h1E0);
    wait_stb_b(n);
    check("late_change_edges", n, 3);
    check_b("late_change", cl, cr, em_b);
    wait_stb_b(n);
    check_b("after_change", 9'h020, 9'h1E0, em_b);

    // Reset sampled at the end of FILT_L aborts the sample.
    repeat (DIV_B - 2) tick_clk();
    set_b(9'h1FF, 9'h1FF);
    rst_b = 1'b0;
    tick_clk();
    check("midop_out_l", s16(out_lb), 0);
    check("midop_out_r", s16(out_rb), 0);
    check("midop_stb", int'(stb_b), 0);
    rst_b = 1'b1; acc_m[2] = 0; acc_m[3] = 0;
    first = 0;
    for (int j = 1; j <= DIV_B + 3; j++) begin
      tick_clk();
      if (stb_b && first == 0) first = j;
    end
    check("midop_first_stb", first, DIV_B + 3);
    check_b("midop_restart", 9'h1FF, 9'h1FF, em_b);

    set_b(9'h1FF, 9'h100);
    reset_b();
    prev_l = 40000; viol = 0; yl = 0;
    for (int i = 0; i < 512; i++) begin
      wait_stb_b(n);
      yl = s16(out_lb); yr = s16(out_rb);
`ifndef AUDIO_EAR_MIX_EN
      if (i == 0) begin
        check("step_first_l", yl, 32640);
        check("step_first_r", yr, 0);
      end
`endif
      check_b("step", 9'h1FF, 9'h100, em_b);
      if (yl > prev_l) viol++;
      prev_l = yl;
    end
    check("step_monotonic_viol", viol, 0);
    check("step_settled_small", int'(yl < 64 && yl > -64), 1);

    pr = s16(out_rb);
    set_b(9'h000, 9'h000);
    wait_stb_b(n);
    check("sat_l", s16(out_lb), -32768);
    check("coherent_r_changed", int'(s16(out_rb) != pr), 1);
    check_b("sat", 9'h000, 9'h000, em_b);
    for (int i = 0; i < 8; i++) begin
      wait_stb_b(n);
      check("sat_no_wrap_l", s16(out_lb), -32768);
      check_b("sat_run", 9'h000, 9'h000, em_b);
    end

    cl = int'($urandom_range(511, 0)); cr = int'($urandom_range(511, 0));
    set_b(cl, cr);
    reset_b();
    for (int i = 0; i < 200; i++) begin
      wait_stb_b(n);
      check_b("rand", cl, cr, em_b);
      cl = int'($urandom_range(511, 0)); cr = int'($urandom_range(511, 0));
      set_b(cl, cr);
`ifdef AUDIO_EAR_MIX_EN
      if (i != 199) begin
        ear_b = 1'($urandom_range(1, 0));
        em_b  = ear_b ? 1 : -1;
      end
`endif
    end

`ifdef AUDIO_EAR_MIX_EN
    set_b(9'h100, 9'h100);
    ear_b = 1'b0; em_b = -1;
    wait_stb_b(n);
    reset_b();
    for (int i = 0; i < 1024; i++) begin
      wait_stb_b(n);
      check_b("ear_settle", 9'h100, 9'h100, em_b);
    end
    ear_b = 1'b1; em_b = 1;
    wait_stb_b(n);
    check("ear_edge_l", s16(out_lb), 4096);
    check("ear_edge_r", s16(out_rb), 4096);
    check_b("ear_edge", 9'h100, 9'h100, em_b);
    prev_l = s16(out_lb);
    for (int i = 0; i < 4; i++) begin
      wait_stb_b(n);
      check("ear_decay", int'(s16(out_lb) < prev_l), 1);
      prev_l = s16(out_lb);
      check_b("ear_decay_model", 9'h100, 9'h100, em_b);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
